// File: rtl/sonar_seg_display.sv
// Snapshot-and-hold 4-digit BCD display driver for the sonar distance counter.
// Multiplexes the held value onto a common 7-segment bus with a blank guard interval per slot.
module sonar_seg_display #(
   parameter int SCAN_DIV       = 3000,
   parameter int GUARD_CYC      = 120,
   parameter bit SEG_ACTIVE_LOW = 1'b1,
   parameter bit DIG_ACTIVE_LOW = 1'b1
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       load,
   input  logic [3:0] count_one,
   input  logic [3:0] count_ten,
   input  logic [3:0] count_hundred,
   input  logic [3:0] count_thousand,
   output logic [7:0] seg,
   output logic [3:0] dig_sel,
   output logic       err
);

   localparam logic [15:0] DIV_LAST  = 16'(SCAN_DIV - 1);
   localparam logic [15:0] GUARD_END = 16'(GUARD_CYC);
   localparam logic [7:0]  SEG_OFF   = {8{SEG_ACTIVE_LOW}};
   localparam logic [3:0]  DIG_OFF   = {4{DIG_ACTIVE_LOW}};
   localparam logic [7:0]  GLYPH_DASH  = 8'h40;
   localparam logic [7:0]  GLYPH_BLANK = 8'h00;

   logic [3:0]  r_one;
   logic [3:0]  r_ten;
   logic [3:0]  r_hun;
   logic [3:0]  r_thou;
   logic        r_err;
   logic [15:0] r_div_cnt;
   logic [1:0]  r_slot;
   logic [7:0]  r_seg;
   logic [3:0]  r_dig_sel;

   logic [3:0]  w_digit;
   logic        w_blank;
   logic [7:0]  w_glyph;
   logic        w_on;
   logic        w_wrap;
   logic [3:0]  w_sel;
   logic        w_err_in;

   // Active-high segment pattern, dp (bit 7) always off.
   function automatic logic [7:0] f_decode(input logic [3:0] d);
      logic [7:0] g;
      case (d)
         4'd0:    g = 8'h3F;
         4'd1:    g = 8'h06;
         4'd2:    g = 8'h5B;
         4'd3:    g = 8'h4F;
         4'd4:    g = 8'h66;
         4'd5:    g = 8'h6D;
         4'd6:    g = 8'h7D;
         4'd7:    g = 8'h07;
         4'd8:    g = 8'h7F;
         4'd9:    g = 8'h6F;
         default: g = GLYPH_DASH;
      endcase
      return g;
   endfunction

   assign w_err_in = (count_one > 4'd9) || (count_ten > 4'd9) ||
                     (count_hundred > 4'd9) || (count_thousand > 4'd9);
   assign w_on     = (r_div_cnt >= GUARD_END);
   assign w_wrap   = (r_div_cnt == DIV_LAST);
   assign w_sel    = 4'b0001 << r_slot;

   // Leading-zero blanking cascades from the thousands digit downward; units never blank.
   always_comb begin
      w_digit = r_one;
      w_blank = 1'b0;
      case (r_slot)
         2'd0: begin
            w_digit = r_one;
            w_blank = 1'b0;
         end
         2'd1: begin
            w_digit = r_ten;
            w_blank = (r_thou == 4'd0) && (r_hun == 4'd0) && (r_ten == 4'd0);
         end
         2'd2: begin
            w_digit = r_hun;
            w_blank = (r_thou == 4'd0) && (r_hun == 4'd0);
         end
         default: begin
            w_digit = r_thou;
            w_blank = (r_thou == 4'd0);
         end
      endcase

      if (r_err)
         w_glyph = GLYPH_DASH;
      else if (w_blank)
         w_glyph = GLYPH_BLANK;
      else
         w_glyph = f_decode(w_digit);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_one     <= 4'd0;
         r_ten     <= 4'd0;
         r_hun     <= 4'd0;
         r_thou    <= 4'd0;
         r_err     <= 1'b0;
         r_div_cnt <= 16'd0;
         r_slot    <= 2'd0;
         r_seg     <= SEG_OFF;
         r_dig_sel <= DIG_OFF;
      end else begin
         if (load) begin
            r_one  <= count_one;
            r_ten  <= count_ten;
            r_hun  <= count_hundred;
            r_thou <= count_thousand;
            r_err  <= w_err_in;
         end

         if (w_wrap) begin
            r_div_cnt <= 16'd0;
            r_slot    <= r_slot + 2'd1;
         end else begin
            r_div_cnt <= r_div_cnt + 16'd1;
         end

         // Outputs follow the current held value and scan position with one cycle of latency.
         if (w_on) begin
            r_seg     <= w_glyph ^ SEG_OFF;
            r_dig_sel <= w_sel ^ DIG_OFF;
         end else begin
            r_seg     <= SEG_OFF;
            r_dig_sel <= DIG_OFF;
         end
      end
   end

   assign seg     = r_seg;
   assign dig_sel = r_dig_sel;
   assign err     = r_err;

endmodule

// File: tb/tb_sonar_seg_display.sv
// Directed bench for sonar_seg_display with SCAN_DIV=8, GUARD_CYC=2, active-low outputs.
module tb_sonar_seg_display;

   localparam int SD = 8;
   localparam int GC = 2;

   logic       clk;
   logic       rstn;
   logic       load;
   logic [3:0] count_one, count_ten, count_hundred, count_thousand;
   logic [7:0] seg;
   logic [3:0] dig_sel;
   logic       err;

   sonar_seg_display #(
      .SCAN_DIV(SD), .GUARD_CYC(GC), .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)
   ) dut (
      .clk(clk), .rstn(rstn), .load(load),
      .count_one(count_one), .count_ten(count_ten),
      .count_hundred(count_hundred), .count_thousand(count_thousand),
      .seg(seg), .dig_sel(dig_sel), .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] th, hu, te, on;
      logic [7:0] g3, g2, g1, g0;
      logic       er;
   } vec_t;

   vec_t       vecs[10];
   int         n_pass = 0;
   int         n_total = 0;
   int         tb_div = 0;
   int         tb_slot = 0;
   logic [7:0] exp_g[4];
   logic       exp_err = 1'b0;

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] expv);
      n_total++;
      if (act === expv) n_pass++;
      else $display("FAIL %s: got %02h expected %02h at t=%0t", nm, act, expv, $time);
   endtask

   task automatic step();
      int p_div, p_slot;
      logic [3:0] e_dig;
      logic [7:0] e_seg;
      p_div  = tb_div;
      p_slot = tb_slot;
      @(posedge clk);
      if (tb_div == SD - 1) begin
         tb_div  = 0;
         tb_slot = (tb_slot + 1) % 4;
      end else begin
         tb_div++;
      end
      @(negedge clk);
      if (p_div < GC) begin
         e_dig = 4'hF;
         e_seg = 8'hFF;
      end else begin
         e_dig = ~(4'b0001 << p_slot);
         e_seg = ~exp_g[p_slot];
      end
      chk("seg", seg, e_seg);
      chk("dig_sel", {4'h0, dig_sel}, {4'h0, e_dig});
      chk("err", {7'h0, err}, {7'h0, exp_err});
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic do_load(input vec_t v);
      count_thousand = v.th;
      count_hundred  = v.hu;
      count_ten      = v.te;
      count_one      = v.on;
      load           = 1'b1;
      exp_err        = v.er;
      step();
      load     = 1'b0;
      exp_g[3] = v.g3;
      exp_g[2] = v.g2;
      exp_g[1] = v.g1;
      exp_g[0] = v.g0;
   endtask

   task automatic wait_pos(input int slot, input int div);
      for (int i = 0; i < 4 * SD + 2 && !(tb_slot == slot && tb_div == div); i++) step();
      if (!(tb_slot == slot && tb_div == div)) begin
         n_total++;
         $display("FAIL wait_pos: reached slot %0d div %0d expected slot %0d div %0d",
                  tb_slot, tb_div, slot, div);
      end
   endtask

   task automatic reset_model();
      tb_div   = 0;
      tb_slot  = 0;
      exp_err  = 1'b0;
      exp_g[3] = 8'h00;
      exp_g[2] = 8'h00;
      exp_g[1] = 8'h00;
      exp_g[0] = 8'h3F;
   endtask

   initial begin
      vecs[0] = '{4'h0, 4'h3, 4'h7, 4'h2, 8'h00, 8'h4F, 8'h07, 8'h5B, 1'b0};
      vecs[1] = '{4'h0, 4'h0, 4'hA, 4'h0, 8'h40, 8'h40, 8'h40, 8'h40, 1'b1};
      vecs[2] = '{4'h0, 4'h0, 4'h0, 4'h5, 8'h00, 8'h00, 8'h00, 8'h6D, 1'b0};
      vecs[3] = '{4'h1, 4'h2, 4'h3, 4'h4, 8'h06, 8'h5B, 8'h4F, 8'h66, 1'b0};
      vecs[4] = '{4'h0, 4'h0, 4'h0, 4'h0, 8'h00, 8'h00, 8'h00, 8'h3F, 1'b0};
      vecs[5] = '{4'h9, 4'h0, 4'h0, 4'h8, 8'h6F, 8'h3F, 8'h3F, 8'h7F, 1'b0};
      vecs[6] = '{4'h0, 4'h1, 4'h0, 4'h0, 8'h00, 8'h06, 8'h3F, 8'h3F, 1'b0};
      vecs[7] = '{4'h0, 4'h0, 4'h6, 4'h0, 8'h00, 8'h00, 8'h7D, 8'h3F, 1'b0};
      vecs[8] = '{4'hF, 4'h1, 4'h1, 4'h1, 8'h40, 8'h40, 8'h40, 8'h40, 1'b1};
      vecs[9] = '{4'h8, 4'h8, 4'h8, 4'h8, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 1'b0};

      rstn = 1'b0;
      load = 1'b0;
      count_one = 4'h0; count_ten = 4'h0; count_hundred = 4'h0; count_thousand = 4'h0;
      reset_model();
      repeat (3) @(negedge clk);
      chk("rst_seg", seg, 8'hFF);
      chk("rst_dig", {4'h0, dig_sel}, 8'h0F);
      chk("rst_err", {7'h0, err}, 8'h00);
      rstn = 1'b1;

      // Post-reset frame shows "   0".
      run(4 * SD);

      // Table: each load followed by a full frame.
      for (int v = 0; v < 10; v++) begin
         do_load(vecs[v]);
         run(4 * SD);
      end

      // Back-to-back loads: the second wins.
      do_load(vecs[3]);
      do_load(vecs[0]);
      run(4 * SD);

      // Load exactly on the div wrap edge.
      wait_pos(1, SD - 1);
      do_load(vecs[5]);
      run(4 * SD);

      // Load during guard.
      wait_pos(3, 0);
      do_load(vecs[7]);
      run(4 * SD);

      // Error then recovery with 0005.
      do_load(vecs[1]);
      run(SD);
      do_load(vecs[2]);
      run(4 * SD);

      // Async reset mid slot 2 while showing 1234.
      do_load(vecs[3]);
      wait_pos(2, 4);
      #2 rstn = 1'b0;
      #1;
      chk("async_rst_seg", seg, 8'hFF);
      chk("async_rst_dig", {4'h0, dig_sel}, 8'h0F);
      chk("async_rst_err", {7'h0, err}, 8'h00);
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      reset_model();
      run(4 * SD);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
